// File: rtl/seven_seg_display_driver_if.sv
// Bus between the register side and the seven-segment display driver.
interface seven_seg_display_driver_if #(
    parameter int unsigned DIGITS = 6
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                blank_lz;
    logic [DIGITS-1:0]   blink_en;
    logic [8*DIGITS-1:0] hex_out;
    logic [7:0]          scan_seg;
    logic [DIGITS-1:0]   scan_sel;

    modport master (
        output value, dp_in, load, blank_lz, blink_en,
        input  hex_out, scan_seg, scan_sel
    );

    modport slave (
        input  value, dp_in, load, blank_lz, blink_en,
        output hex_out, scan_seg, scan_sel
    );
endinterface

// File: rtl/seven_seg_display_driver.sv
// Multi-digit hex display driver: static per-digit segment bytes plus a
// time-multiplexed scan output, with decimal points, leading-zero blanking
// and per-digit blinking.
module seven_seg_display_driver #(
    parameter int unsigned DIGITS     = 6,
    parameter int unsigned BLINK_DIV  = 25000000,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    seven_seg_display_driver_if.slave     bus
);

    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // XOR masks turning logical "lit = 1" into the physical pin level
    localparam logic [7:0]        SEG_POL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_POL = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [4*DIGITS-1:0] r_val;
    logic [DIGITS-1:0]   r_dp;
    logic                r_loaded;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic                r_blink_phase;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [IDX_W-1:0]    r_scan_idx;
    logic [8*DIGITS-1:0] r_hex;
    logic [7:0]          r_scan_seg;
    logic [DIGITS-1:0]   r_scan_sel;

    logic [7:0]          w_byte [DIGITS];
    logic [8*DIGITS-1:0] w_hex;
    logic [DIGITS-1:0]   w_sel;

    // Logical a..g pattern for one hex nibble
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Latch the display value and decimal points on a load strobe
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_val    <= '0;
            r_dp     <= '0;
            r_loaded <= 1'b0;
        end else if (bus.load) begin
            r_val    <= bus.value;
            r_dp     <= bus.dp_in;
            r_loaded <= 1'b1;
        end
    end

    // Free-running blink timebase; phase flips each time the counter wraps
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
        end
    end

    // Scan timebase; the digit index advances on every counter wrap
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            if (r_scan_idx == IDX_W'(DIGITS - 1)) begin
                r_scan_idx <= '0;
            end else begin
                r_scan_idx <= r_scan_idx + IDX_W'(1);
            end
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Per-digit byte: glyph + dp, then leading-zero blank, then blink, then not-loaded
    always_comb begin
        logic       v_zero_above;
        logic [3:0] v_nib;
        logic [7:0] v_seg;
        v_zero_above = 1'b1;
        v_nib        = '0;
        v_seg        = '0;
        w_hex        = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_nib        = r_val[4*i +: 4];
            v_seg        = {r_dp[i], glyph(v_nib)};
            v_zero_above = v_zero_above && (v_nib == 4'h0);
            if (bus.blank_lz && v_zero_above && (i != 0)) begin
                v_seg[6:0] = 7'h00;
            end
            if (bus.blink_en[i] && r_blink_phase) begin
                v_seg = 8'h00;
            end
            if (!r_loaded) begin
                v_seg = 8'h00;
            end
            w_byte[i]        = v_seg;
            w_hex[8*i +: 8]  = v_seg ^ SEG_POL;
        end
    end

    assign w_sel = DIGITS'(1) << r_scan_idx;

    // Register static and scan outputs from the same combinational result
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hex      <= {DIGITS{SEG_POL}};
            r_scan_seg <= SEG_POL;
            r_scan_sel <= DIGITS'(1) ^ SEL_POL;
        end else begin
            r_hex      <= w_hex;
            r_scan_seg <= w_byte[r_scan_idx] ^ SEG_POL;
            r_scan_sel <= w_sel ^ SEL_POL;
        end
    end

    assign bus.hex_out  = r_hex;
    assign bus.scan_seg = r_scan_seg;
    assign bus.scan_sel = r_scan_sel;

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Directed bench for the seven-segment display driver (6 digits, active-low).
module tb_seven_seg_display_driver;

    localparam int unsigned DIGITS     = 6;
    localparam int unsigned BLINK_DIV  = 4;
    localparam int unsigned SCAN_DIV   = 2;
    localparam int unsigned ACTIVE_LOW = 1;

    localparam logic [47:0] ALL_OFF = 48'hFFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_since  = 0;

    always #5 clk = ~clk;

    seven_seg_display_driver_if #(.DIGITS(DIGITS)) bus ();

    seven_seg_display_driver #(
        .DIGITS     (DIGITS),
        .BLINK_DIV  (BLINK_DIV),
        .SCAN_DIV   (SCAN_DIV),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    // Non-reset edges since the last reset edge; drives the scan expectation
    always @(posedge clk) begin
        if (reset) n_since <= 0;
        else       n_since <= n_since + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [23:0] v, input logic [5:0] dp);
        bus.value = v;
        bus.dp_in = dp;
        bus.load  = 1'b1;
        tick(1);
        bus.load  = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [7:0]  prev;
        logic [7:0]  x;
        logic [7:0]  lit;
        logic        vis;
        logic        changed;
        logic [5:0]  sel_exp;
        logic [47:0] exp48;
        int          e;

        reset        = 1'b1;
        bus.value    = '0;
        bus.dp_in    = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        bus.blink_en = '0;

        // Reset state
        tick(2);
        check("rst_hex", 64'(bus.hex_out), 64'(ALL_OFF));
        check("rst_seg", 64'(bus.scan_seg), 64'(8'hFF));
        check("rst_sel", 64'(bus.scan_sel), 64'(6'b111110));
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_hex", 64'(bus.hex_out), 64'(ALL_OFF));
            check("idle_seg", 64'(bus.scan_seg), 64'(8'hFF));
        end

        // Decode and two-edge load latency
        bus.value = 24'h0123AF;
        bus.dp_in = '0;
        bus.load  = 1'b1;
        tick(1);
        bus.load  = 1'b0;
        check("lat_edge_k", 64'(bus.hex_out), 64'(ALL_OFF));
        tick(1);
        check("dec_0123AF", 64'(bus.hex_out), 64'(48'hC0F9A4B0888E));
        load_word(24'h456789, 6'b0);
        check("dec_456789", 64'(bus.hex_out), 64'(48'h999282F88090));
        load_word(24'hBCDE00, 6'b0);
        check("dec_BCDE00", 64'(bus.hex_out), 64'(48'h83C6A186C0C0));

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        load_word(24'h00000A, 6'b0);
        check("lz_00000A", 64'(bus.hex_out), 64'(48'hFFFFFFFFFF88));
        load_word(24'h000000, 6'b0);
        check("lz_zero", 64'(bus.hex_out), 64'(48'hFFFFFFFFFFC0));
        load_word(24'h000000, 6'b000010);
        check("lz_dp", 64'(bus.hex_out), 64'(48'hFFFFFFFF7FC0));
        bus.blank_lz = 1'b0;
        tick(1);
        check("lz_live_off", 64'(bus.hex_out), 64'(48'hC0C0C0C040C0));
        bus.blank_lz = 1'b1;
        load_word(24'h000100, 6'b0);
        check("lz_inner_zero", 64'(bus.hex_out), 64'(48'hFFFFFFF9C0C0));
        bus.blank_lz = 1'b0;

        // Blink on digit 0 with a load on a wrap edge
        load_word(24'h000005, 6'b0);
        check("blink_pre", 64'(bus.hex_out), 64'(48'hC0C0C0C0C092));
        bus.blink_en = 6'b000001;
        tick(1);
        prev    = bus.hex_out[7:0];
        changed = 1'b0;
        for (int k = 0; k < 8 && !changed; k++) begin
            tick(1);
            if (bus.hex_out[7:0] !== prev) changed = 1'b1;
        end
        check("blink_seen", 64'(changed), 64'(1'b1));
        x = bus.hex_out[7:0];
        check("blink_first", 64'(x), 64'((prev == 8'h92) ? 8'hFF : 8'h92));
        lit = 8'h92;
        vis = (x != 8'hFF);
        for (int h = 0; h < 4; h++) begin
            for (int j = 1; j <= 3; j++) begin
                if (h == 0 && j == 3) begin
                    bus.value = 24'h000007;
                    bus.load  = 1'b1;
                end
                tick(1);
                bus.load = 1'b0;
                check("blink_hold", 64'(bus.hex_out[7:0]), 64'(vis ? lit : 8'hFF));
                check("blink_others", 64'(bus.hex_out[47:8]), 64'(40'hC0C0C0C0C0));
            end
            tick(1);
            if (h == 0) lit = 8'hF8;
            vis = !vis;
            check("blink_flip", 64'(bus.hex_out[7:0]), 64'(vis ? lit : 8'hFF));
        end
        bus.blink_en = '0;

        // Scan output sequence and consistency
        load_word(24'h0123AF, 6'b100001);
        exp48 = 48'h40F9A4B0880E;
        check("scan_hex", 64'(bus.hex_out), 64'(exp48));
        for (int c = 0; c < 26; c++) begin
            tick(1);
            e       = (n_since == 0) ? 0 : ((n_since - 1) / 2) % 6;
            sel_exp = ~(6'(1) << e);
            check("scan_sel", 64'(bus.scan_sel), 64'(sel_exp));
            check("scan_seg", 64'(bus.scan_seg), 64'(exp48[8*e +: 8]));
            check("scan_onecold", 64'($countones(~bus.scan_sel)), 64'(1));
        end

        // Reset mid-scan with a simultaneous load
        bus.value = 24'h111111;
        bus.load  = 1'b1;
        reset     = 1'b1;
        tick(1);
        reset    = 1'b0;
        bus.load = 1'b0;
        check("mid_rst_hex", 64'(bus.hex_out), 64'(ALL_OFF));
        check("mid_rst_seg", 64'(bus.scan_seg), 64'(8'hFF));
        check("mid_rst_sel", 64'(bus.scan_sel), 64'(6'b111110));
        tick(2);
        check("mid_rst_noload", 64'(bus.hex_out), 64'(ALL_OFF));
        check("mid_rst_seg2", 64'(bus.scan_seg), 64'(8'hFF));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
